led_fade_pwm: RTL and testbench
===============================

Name: led_fade_pwm

Overview:
- Downstream stage of the 4-bit flow_led running-light generator; consumes its led pattern and drives the board LED pins.
- Converts the hard on/off pattern into a comet-tail effect. Each channel has a brightness register:
  - reloaded to full while its input bit is high;
  - decays in fixed steps after the bit drops;
  - rendered to the pin through a shared 8-bit PWM.

Parameters:
- CH, 4, number of LED channels (matches flow_led width).
- TICK_DIV, 50000, decay prescaler period in sys_clk cycles (1 ms at 50 MHz); legal range 2..2^20.
- DECAY_STEP, 8, brightness decrement per decay tick; legal range 1..255.

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst  input  1  asynchronous active-high reset.
- fade_en  input  1  1 = fade/PWM active; 0 = direct pass-through of led_in.
- led_in  input  CH  on/off pattern from flow_led, synchronous to sys_clk.
- led_out  output  CH  PWM-driven LED pins, registered, active-high.

Behaviour:
- Reset: one clock (sys_clk); reset is asynchronous and active-high (sys_rst). While sys_rst=1 all state clears asynchronously:
  - prescaler=0, pwm_cnt=0, all bright[i]=0, led_out=0.
  - Reset mid-fade discards all brightness; first edge after release starts from the cleared state.
- Prescaler:
  - Counts 0..TICK_DIV-1 then wraps to 0.
  - tick=1 for exactly the one cycle the count equals TICK_DIV-1.
- PWM counter: 8-bit, counts 0..254 then wraps to 0; period 255 cycles, free-running regardless of fade_en.
- Brightness update per channel i, evaluated each cycle in this priority order:
  1. led_in[i]=1 -> bright[i]<=255. Load wins over a simultaneous tick.
  2. else if tick -> bright[i] <= bright[i] < DECAY_STEP ? 0 : bright[i]-DECAY_STEP. Saturates at 0, never wraps.
  3. else hold.
- Output compare:
  - led_out[i] <= (eff[i] > pwm_cnt), registered.
  - eff[i]=bright[i] (see Optional Feature).
  - bright=255 -> constantly on; bright=0 -> constantly off; bright=N -> high N of every 255 cycles, on pwm_cnt 0..N-1.
- Latency: led_in rise -> bright=255 on the next edge -> led_out=1 one edge later (2 cycles), for any pwm_cnt.
- fade_en=0:
  - led_out[i] <= led_in[i] (1-cycle registered pass-through).
  - Brightness and prescaler logic still run, so re-enabling fade resumes with current bright values and no glitch beyond one cycle.
- No other handshake; led_in is sampled every cycle and may change on any cycle.

Optional Feature:
- Macro LED_FADE_GAMMA_EN.
- Defined: eff[i] = (bright[i]*bright[i] + bright[i]) >> 8, using a 16-bit intermediate and 8-bit result.
  - Maps 0->0, 255->255, 128->64, 64->16; gives a perceptually linear fade.
  - Compare stays registered; latency stays 2 cycles.
- Undefined: eff[i]=bright[i] (linear); no multiplier inferred.

Test Plan (TICK_DIV=4, DECAY_STEP=64 unless noted):
- Reset: sys_rst=1 asserted mid-run with bright[0]=191 -> led_out=4'b0000 immediately (asynchronous); after release, bright all 0 and led_out stays 0 with led_in=0.
- Load/latency: fade_en=1, led_in 0->4'b0001 at cycle t -> led_out[0]=1 from cycle t+2 onward, constant for ≥510 cycles while held.
- Decay sequence: led_in[0] held then dropped -> bright[0] goes 255,191,127,63,0 on successive ticks, 4 cycles apart, then stays 0. At bright=127, led_out[0] is high exactly 127 of 255 cycles.
- Saturation/priority:
  - DECAY_STEP=200: bright 255 -> 55 -> 0, never wraps.
  - led_in[1] re-asserted on a tick cycle -> bright[1]=255, not decremented.
- Bypass: fade_en=0, led_in=4'b1010 -> led_out=4'b1010 one cycle later. Return fade_en=1 after releasing led_in -> channels 1 and 3 fade from their current bright values.
- Gamma (LED_FADE_GAMMA_EN defined): bright=128 -> led_out high 64 of 255 cycles; bright=255 -> always high; bright=0 -> always low.

Source files
------------

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: comet-tail fader behind flow_led, per-channel decay + shared PWM.
// Define LED_FADE_GAMMA_EN to apply a square-law curve on the compare path.
module led_fade_pwm #(
  parameter int CH         = 4,
  parameter int TICK_DIV   = 50000,
  parameter int DECAY_STEP = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          fade_en,
  input  logic [CH-1:0] led_in,
  output logic [CH-1:0] led_out
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] STEP = 8'(DECAY_STEP);

  logic [PW-1:0]        presc;
  logic                 tick;
  logic [7:0]           pwm_cnt;
  logic [CH-1:0][7:0]   bright;
  logic [CH-1:0][7:0]   eff;

  assign tick = (presc == TICK_LAST);

  // decay prescaler, wraps after TICK_DIV cycles
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)   presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // free-running PWM ramp, 255-cycle period
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                pwm_cnt <= '0;
    else if (pwm_cnt == 8'd254) pwm_cnt <= '0;
    else                        pwm_cnt <= pwm_cnt + 8'd1;
  end

  // brightness: reload on input high, else saturating decay on tick
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bright <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (led_in[i])
          bright[i] <= 8'hFF;
        else if (tick)
          bright[i] <= (bright[i] < STEP) ? 8'd0
                     : bright[i] - STEP;
      end
    end
  end

`ifdef LED_FADE_GAMMA_EN
  // square-law curve: (b*b + b) >> 8 keeps 0->0 and 255->255
  always_comb begin
    eff = '0;
    for (int i = 0; i < CH; i++)
      eff[i] = 8'((16'(bright[i]) * 16'(bright[i])
                 + 16'(bright[i])) >> 8);
  end
`else
  // linear: duty follows brightness directly
  always_comb begin
    eff = bright;
  end
`endif

  // registered pin drive: PWM compare or direct pass-through
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      led_out <= '0;
    end else begin
      for (int i = 0; i < CH; i++)
        led_out[i] <= fade_en ? (eff[i] > pwm_cnt)
                              : led_in[i];
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: directed checks of load, decay, PWM duty, bypass, reset.
// Three instances cover fast decay, saturating step and long-hold duty.
module tb_led_fade_pwm;

  logic       clk = 1'b0;
  logic       rst;
  logic       fade_en;
  logic [3:0] led_in, led_in_b, led_in_c;
  logic [3:0] led_out_a, led_out_b, led_out_c;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] seen_v[$];
  int         seen_t[$];
  logic [7:0] exp_a[4] = '{8'd191, 8'd127, 8'd63, 8'd0};
  logic [7:0] exp_b[2] = '{8'd55, 8'd0};

  always #5 clk = ~clk;

  led_fade_pwm #(.CH(4), .TICK_DIV(4), .DECAY_STEP(64)) u_a (
    .sys_clk(clk), .sys_rst(rst), .fade_en(fade_en),
    .led_in(led_in), .led_out(led_out_a)
  );

  led_fade_pwm #(.CH(4), .TICK_DIV(4), .DECAY_STEP(200)) u_b (
    .sys_clk(clk), .sys_rst(rst), .fade_en(1'b1),
    .led_in(led_in_b), .led_out(led_out_b)
  );

  led_fade_pwm #(.CH(4), .TICK_DIV(1000), .DECAY_STEP(127)) u_c (
    .sys_clk(clk), .sys_rst(rst), .fade_en(1'b1),
    .led_in(led_in_c), .led_out(led_out_c)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] get_b(input int d, input int ch);
    case (d)
      0:       return u_a.bright[ch];
      1:       return u_b.bright[ch];
      default: return u_c.bright[ch];
    endcase
  endfunction

  // record each brightness change and the cycle it appeared
  task automatic watch(input int d, input int ch, input int n);
    logic [7:0] prev, cur;
    seen_v.delete();
    seen_t.delete();
    prev = get_b(d, ch);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cur = get_b(d, ch);
      if (cur != prev) begin
        seen_v.push_back(cur);
        seen_t.push_back(k);
      end
      prev = cur;
    end
  endtask

  task automatic wait_b(input int d, input int ch,
                        input logic [7:0] v, input int lim,
                        input string tag);
    int k = 0;
    while (get_b(d, ch) !== v && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, get_b(d, ch), v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int hi;
    rst      = 1'b1;
    fade_en  = 1'b1;
    led_in   = '0;
    led_in_b = '0;
    led_in_c = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", led_out_a, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_bright", u_a.bright, 0);
    chk("rst_idle", led_out_a, 0);

    // load and two-cycle latency, then steady on
    led_in = 4'b0001;
    @(negedge clk);
    chk("lat_bright", get_b(0, 0), 255);
    chk("lat_edge1", led_out_a[0], 0);
    @(negedge clk);
    chk("lat_edge2", led_out_a[0], 1);
    bad = 0;
    for (int k = 0; k < 510; k++) begin
      @(negedge clk);
      if (led_out_a[0] !== 1'b1) bad++;
    end
    chk("hold_on", bad, 0);

    // decay 255,191,127,63,0 four cycles apart
    led_in = 4'b0000;
    watch(0, 0, 30);
    chk("decay_n", seen_v.size(), 4);
    for (int j = 0; j < 4 && j < seen_v.size(); j++)
      chk("decay_v", seen_v[j], exp_a[j]);
    for (int j = 1; j < 4 && j < seen_t.size(); j++)
      chk("decay_dt", seen_t[j] - seen_t[j-1], 4);
    chk("decay_off", led_out_a, 0);

    // saturation with step 200: 255 -> 55 -> 0
    led_in_b = 4'b0001;
    repeat (2) @(negedge clk);
    led_in_b = 4'b0000;
    watch(1, 0, 30);
    chk("sat_n", seen_v.size(), 2);
    for (int j = 0; j < 2 && j < seen_v.size(); j++)
      chk("sat_v", seen_v[j], exp_b[j]);

    // duty at brightness 128, held by the slow prescaler
    led_in_c = 4'b0001;
    @(negedge clk);
    led_in_c = 4'b0000;
    wait_b(2, 0, 8'd128, 1100, "duty_reach");
    repeat (2) @(negedge clk);
    hi = 0;
    for (int k = 0; k < 255; k++) begin
      @(negedge clk);
      if (led_out_c[0] === 1'b1) hi++;
    end
`ifdef LED_FADE_GAMMA_EN
    chk("duty128", hi, 64);
`else
    chk("duty128", hi, 128);
`endif

    // load wins over a simultaneous tick
    led_in = 4'b1010;
    @(negedge clk);
    led_in = 4'b0000;
    wait_b(0, 1, 8'd191, 10, "prio_first");
    repeat (3) @(negedge clk);
    led_in = 4'b0010;
    @(negedge clk);
    chk("prio_load", get_b(0, 1), 255);
    chk("prio_tick", get_b(0, 3), 127);
    led_in = 4'b0000;
    wait_b(0, 1, 8'd0, 40, "prio_drain");

    // bypass follows led_in with one cycle delay
    fade_en = 1'b0;
    led_in  = 4'b1010;
    @(negedge clk);
    chk("byp1", led_out_a, 4'b1010);
    led_in = 4'b0101;
    @(negedge clk);
    chk("byp2", led_out_a, 4'b0101);
    led_in = 4'b1010;
    repeat (2) @(negedge clk);
    led_in = 4'b0000;
    @(negedge clk);
    chk("byp_zero", led_out_a, 0);
    chk("byp_keep", get_b(0, 3) >= 8'd191, 1);
    fade_en = 1'b1;
    wait_b(0, 3, 8'd0, 30, "byp_fade3");
    chk("byp_fade1", get_b(0, 1), 0);
    repeat (2) @(negedge clk);
    chk("byp_off", led_out_a, 0);

    // asynchronous reset mid-fade
    fade_en = 1'b0;
    led_in  = 4'b1001;
    repeat (2) @(negedge clk);
    led_in = 4'b1000;
    wait_b(0, 0, 8'd191, 10, "pre_rst_b");
    chk("pre_rst_out", led_out_a, 4'b1000);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_out", led_out_a, 0);
    chk("async_bright", u_a.bright, 0);
    @(negedge clk);
    led_in  = 4'b0000;
    fade_en = 1'b1;
    rst     = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (led_out_a !== 4'b0000 || u_a.bright !== '0) bad++;
    end
    chk("post_rst", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
